// File: rtl/pipe_writeback_ctrl_pkg.sv
// Shared types and constants for the writeback sequencer: result-source codes,
// load-tracker state encoding and the load-detect helper.
package pipe_writeback_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SRC_PCIMM = 2'd0,
        SRC_PC4   = 2'd1,
        SRC_LOAD  = 2'd2,
        SRC_ALU   = 2'd3
    } resultSrcE;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_WAIT   = 2'd1,
        LD_COMMIT = 2'd2
    } ldStateE;

    function automatic logic isLoadInstr(input logic valid, input logic [1:0] resultSrc);
        return valid && (resultSrc == 2'(SRC_LOAD));
    endfunction

endpackage

// File: rtl/pipe_writeback_ctrl_if.sv
// Bundle of W-stage, data-memory, debug and register-file signals around the
// writeback sequencer. The slave side is the sequencer itself.
interface pipe_writeback_ctrl_if;
    import pipe_writeback_ctrl_pkg::*;

    logic            i_wb_valid;
    logic            i_wb_regwrite;
    logic [4:0]      i_wb_rd;
    logic [1:0]      i_wb_resultsrc;
    logic [XLEN-1:0] i_dp_resultW;
    logic            i_dmem_rvalid;
    logic [XLEN-1:0] i_dmem_rdata;
    logic            i_dbg_wr_req;
    logic [4:0]      i_dbg_rd;
    logic [XLEN-1:0] i_dbg_wdata;

    logic [1:0]      o_resultsrc;
    logic [XLEN-1:0] o_load_data;
    logic            o_rf_we;
    logic [4:0]      o_rf_rd;
    logic [XLEN-1:0] o_rf_wdata;
    logic            o_stall;
    logic            o_dbg_wr_ack;
    logic            o_ld_timeout;

    modport master (
        output i_wb_valid, i_wb_regwrite, i_wb_rd, i_wb_resultsrc, i_dp_resultW,
        output i_dmem_rvalid, i_dmem_rdata, i_dbg_wr_req, i_dbg_rd, i_dbg_wdata,
        input  o_resultsrc, o_load_data, o_rf_we, o_rf_rd, o_rf_wdata,
        input  o_stall, o_dbg_wr_ack, o_ld_timeout
    );

    modport slave (
        input  i_wb_valid, i_wb_regwrite, i_wb_rd, i_wb_resultsrc, i_dp_resultW,
        input  i_dmem_rvalid, i_dmem_rdata, i_dbg_wr_req, i_dbg_rd, i_dbg_wdata,
        output o_resultsrc, o_load_data, o_rf_we, o_rf_rd, o_rf_wdata,
        output o_stall, o_dbg_wr_ack, o_ld_timeout
    );

endinterface

// File: rtl/pipe_writeback_ctrl_ld_tracker.sv
// Load tracker: waits for variable-latency load data, abandons the load after
// TIMEOUT_CYCLES wait cycles, and holds the captured word for the commit write.
module pipe_wb_ld_tracker
    import pipe_writeback_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            isLoad,
    input  logic            rvalid,
    input  logic [XLEN-1:0] rdata,
    output ldStateE         ldState,
    output logic            ldStall,
    output logic            ldTimeout,
    output logic            inCommit,
    output logic [XLEN-1:0] loadData
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ldStateE          stateQ, stateD;
    logic [CNT_W-1:0] toCntQ, toCntD;
    logic [XLEN-1:0]  bufQ, bufD;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateQ <= LD_IDLE;
            toCntQ <= '0;
            bufQ   <= '0;
        end else begin
            stateQ <= stateD;
            toCntQ <= toCntD;
            bufQ   <= bufD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        toCntD    = toCntQ;
        bufD      = bufQ;
        ldStall   = 1'b0;
        ldTimeout = 1'b0;
        case (stateQ)
            LD_IDLE: begin
                if (isLoad) begin
                    ldStall = 1'b1;
                    toCntD  = '0;
                    if (rvalid) begin
                        bufD   = rdata;
                        stateD = LD_COMMIT;
                    end else begin
                        stateD = LD_WAIT;
                    end
                end
            end
            LD_WAIT: begin
                ldStall = 1'b1;
                // Data arriving in the final wait cycle still beats the timeout.
                if (rvalid) begin
                    bufD   = rdata;
                    toCntD = '0;
                    stateD = LD_COMMIT;
                end else if (toCntQ == TO_LAST) begin
                    bufD      = '0;
                    toCntD    = '0;
                    ldTimeout = 1'b1;
                    stateD    = LD_COMMIT;
                end else begin
                    toCntD = toCntQ + 1'b1;
                end
            end
            LD_COMMIT: begin
                stateD = LD_IDLE;
            end
            default: begin
                stateD = LD_IDLE;
            end
        endcase
    end

    assign ldState  = stateQ;
    assign inCommit = (stateQ == LD_COMMIT);
    assign loadData = bufQ;

endmodule

// File: rtl/pipe_writeback_ctrl.sv
// Register-file write-port sequencer: load stall/commit via the load tracker,
// debug-write arbitration with a bounded wait, and the write-port mux.
module pipe_writeback_ctrl
    import pipe_writeback_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DBG_MAX_WAIT   = 4
) (
    input logic                  i_clk,
    input logic                  i_rstn,
    pipe_writeback_ctrl_if.slave bus
);

    localparam logic [7:0] DBG_LIMIT = 8'(DBG_MAX_WAIT);

    ldStateE         ldState;
    logic            ldStall;
    logic            ldTimeout;
    logic            inCommit;
    logic [XLEN-1:0] loadData;

    logic            isLoad;
    logic            idle;
    logic            pipeWrite;
    logic            dbgOpen;
    logic            forceGrant;
    logic            grant;
    logic [7:0]      waitQ;

    logic [1:0]      resultSrc;
    logic            rfWe;
    logic [4:0]      rfRd;
    logic [XLEN-1:0] rfWdata;
    logic            stall;

    assign isLoad = isLoadInstr(bus.i_wb_valid, bus.i_wb_resultsrc);

    pipe_wb_ld_tracker #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ldTracker (
        .clk      (i_clk),
        .rstn     (i_rstn),
        .isLoad   (isLoad),
        .rvalid   (bus.i_dmem_rvalid),
        .rdata    (bus.i_dmem_rdata),
        .ldState  (ldState),
        .ldStall  (ldStall),
        .ldTimeout(ldTimeout),
        .inCommit (inCommit),
        .loadData (loadData)
    );

    // Debug only competes for the port in IDLE with no load in W; the pipeline
    // wins unless the request has already waited DBG_MAX_WAIT cycles.
    always_comb begin
        idle       = (ldState == LD_IDLE);
        pipeWrite  = idle && !isLoad && bus.i_wb_valid && bus.i_wb_regwrite
                     && (bus.i_wb_rd != 5'd0);
        dbgOpen    = idle && !isLoad && bus.i_dbg_wr_req;
        forceGrant = dbgOpen && (waitQ == DBG_LIMIT);
        grant      = dbgOpen && (!pipeWrite || forceGrant);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            waitQ <= '0;
        end else if (grant) begin
            waitQ <= '0;
        end else if (bus.i_dbg_wr_req && (waitQ < DBG_LIMIT)) begin
            waitQ <= waitQ + 1'b1;
        end
    end

    always_comb begin
        resultSrc = bus.i_wb_resultsrc;
        rfWe      = 1'b0;
        rfRd      = bus.i_wb_rd;
        rfWdata   = bus.i_dp_resultW;
        stall     = ldStall;
        if (inCommit) begin
            resultSrc = 2'(SRC_LOAD);
            rfWe      = bus.i_wb_regwrite && (bus.i_wb_rd != 5'd0);
            rfWdata   = loadData;
        end else if (!idle) begin
            resultSrc = 2'(SRC_LOAD);
        end else if (grant) begin
            rfWe    = (bus.i_dbg_rd != 5'd0);
            rfRd    = bus.i_dbg_rd;
            rfWdata = bus.i_dbg_wdata;
            stall   = forceGrant;
        end else begin
            rfWe = pipeWrite;
        end
    end

    // Every output, registered or not, is forced low while reset is held.
    assign bus.o_resultsrc  = i_rstn ? resultSrc : 2'd0;
    assign bus.o_load_data  = i_rstn ? loadData  : '0;
    assign bus.o_rf_we      = i_rstn && rfWe;
    assign bus.o_rf_rd      = i_rstn ? rfRd      : 5'd0;
    assign bus.o_rf_wdata   = i_rstn ? rfWdata   : '0;
    assign bus.o_stall      = i_rstn && stall;
    assign bus.o_dbg_wr_ack = i_rstn && grant;
    assign bus.o_ld_timeout = i_rstn && ldTimeout;

endmodule

// File: tb/tb_pipe_writeback_ctrl.sv
// Bench for pipe_writeback_ctrl: directed vectors, multi-cycle load/debug/reset
// sequences, then random traffic against a cycle-level reference model.
`timescale 1ns/1ps
module tb_pipe_writeback_ctrl;
    import pipe_writeback_ctrl_pkg::*;

    localparam int TO  = 8;
    localparam int DMW = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    pipe_writeback_ctrl_if bus ();

    pipe_writeback_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .DBG_MAX_WAIT  (DMW)
    ) dut (
        .i_clk (clk),
        .i_rstn(rstn),
        .bus   (bus)
    );

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic [31:0] dp;
        logic        req;
        logic [4:0]  dRd;
        logic [31:0] dData;
        logic        eWe;
        logic [4:0]  eRd;
        logic [31:0] eWd;
        logic [1:0]  eSrc;
        logic        eStall;
        logic        eAck;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setW(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [1:0] src, input logic [31:0] dp);
        bus.i_wb_valid     = v;
        bus.i_wb_regwrite  = rw;
        bus.i_wb_rd        = rd;
        bus.i_wb_resultsrc = src;
        bus.i_dp_resultW   = dp;
    endtask

    task automatic setDbg(input logic req, input logic [4:0] rd, input logic [31:0] d);
        bus.i_dbg_wr_req = req;
        bus.i_dbg_rd     = rd;
        bus.i_dbg_wdata  = d;
    endtask

    // Reference model state: "load outstanding", "commit due", wait age, buffer.
    bit          mWait, mCommit, isLd, pipeWr, forceG, grantM, gotAck;
    int          mAge, mDbgWait, stalls;
    bit          seen;
    logic [31:0] mBuf, nBuf, eWd;
    logic [4:0]  eRd;
    logic [1:0]  eSrc;
    bit          eStall, eWe, eAck, eTo;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 5'd5,  2'd3, 32'h0000_1234, 1'b0, 5'd0,  32'h0,      1'b1, 5'd5,  32'h0000_1234, 2'd3, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 5'd1,  2'd1, 32'h0000_0104, 1'b0, 5'd0,  32'h0,      1'b1, 5'd1,  32'h0000_0104, 2'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 5'd31, 2'd0, 32'h8000_0000, 1'b0, 5'd0,  32'h0,      1'b1, 5'd31, 32'h8000_0000, 2'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 5'd0,  2'd3, 32'h0000_FFFF, 1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,         2'd3, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'd6,  2'd3, 32'h0000_0042, 1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,         2'd3, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 5'd6,  2'd3, 32'h0000_0042, 1'b0, 5'd0,  32'h0,      1'b0, 5'd0,  32'h0,         2'd3, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 5'd0,  2'd3, 32'h0,         1'b1, 5'd3,  32'h0000_00A5, 1'b1, 5'd3, 32'h0000_00A5, 2'd3, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 5'd0,  2'd3, 32'h0,         1'b1, 5'd0,  32'h0000_0077, 1'b0, 5'd0, 32'h0,         2'd3, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 1'b0, 5'd8,  2'd1, 32'h0000_0009, 1'b1, 5'd4,  32'h0000_CAFE, 1'b1, 5'd4, 32'h0000_CAFE, 2'd1, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 5'd0,  2'd3, 32'h0000_0009, 1'b1, 5'd30, 32'h0000_0001, 1'b1, 5'd30, 32'h0000_0001, 2'd3, 1'b0, 1'b1};

        bus.i_dmem_rvalid = 1'b0;
        bus.i_dmem_rdata  = '0;
        setW(1'b1, 1'b1, 5'd5, 2'd3, 32'h1234);
        setDbg(1'b1, 5'd3, 32'hA5);

        // Reset: all outputs low even with active inputs.
        repeat (2) tick();
        @(negedge clk);
        chk("rst_we",     32'(bus.o_rf_we), 32'd0);
        chk("rst_rd",     32'(bus.o_rf_rd), 32'd0);
        chk("rst_wdata",  bus.o_rf_wdata, 32'd0);
        chk("rst_src",    32'(bus.o_resultsrc), 32'd0);
        chk("rst_stall",  32'(bus.o_stall), 32'd0);
        chk("rst_ack",    32'(bus.o_dbg_wr_ack), 32'd0);
        chk("rst_to",     32'(bus.o_ld_timeout), 32'd0);
        chk("rst_ldata",  bus.o_load_data, 32'd0);
        tick();
        rstn = 1'b1;
        setW(1'b0, 1'b0, 5'd0, 2'd0, 32'h0);
        setDbg(1'b0, 5'd0, 32'h0);
        tick();

        // Single-cycle vectors in IDLE.
        for (int i = 0; i < 10; i++) begin
            setW(vecs[i].valid, vecs[i].rw, vecs[i].rd, vecs[i].src, vecs[i].dp);
            setDbg(vecs[i].req, vecs[i].dRd, vecs[i].dData);
            @(negedge clk);
            chk($sformatf("vec%0d_we", i),    32'(bus.o_rf_we), 32'(vecs[i].eWe));
            chk($sformatf("vec%0d_src", i),   32'(bus.o_resultsrc), 32'(vecs[i].eSrc));
            chk($sformatf("vec%0d_stall", i), 32'(bus.o_stall), 32'(vecs[i].eStall));
            chk($sformatf("vec%0d_ack", i),   32'(bus.o_dbg_wr_ack), 32'(vecs[i].eAck));
            if (vecs[i].eWe) begin
                chk($sformatf("vec%0d_rd", i),    32'(bus.o_rf_rd), 32'(vecs[i].eRd));
                chk($sformatf("vec%0d_wdata", i), bus.o_rf_wdata, vecs[i].eWd);
            end
            tick();
        end
        setW(1'b0, 1'b0, 5'd0, 2'd0, 32'h0);
        setDbg(1'b0, 5'd0, 32'h0);
        tick();

        // Load to x7, data 3 cycles later: 4 stall cycles then commit.
        setW(1'b1, 1'b1, 5'd7, 2'd2, 32'h1111_1111);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                bus.i_dmem_rvalid = 1'b1;
                bus.i_dmem_rdata  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            chk($sformatf("ld_stall_c%0d", c), 32'(bus.o_stall), 32'd1);
            chk($sformatf("ld_we_c%0d", c),    32'(bus.o_rf_we), 32'd0);
            tick();
            bus.i_dmem_rvalid = 1'b0;
        end
        @(negedge clk);
        chk("ld_commit_stall", 32'(bus.o_stall), 32'd0);
        chk("ld_commit_we",    32'(bus.o_rf_we), 32'd1);
        chk("ld_commit_rd",    32'(bus.o_rf_rd), 32'd7);
        chk("ld_commit_wdata", bus.o_rf_wdata, 32'hDEAD_BEEF);
        chk("ld_commit_src",   32'(bus.o_resultsrc), 32'd2);
        chk("ld_commit_ldata", bus.o_load_data, 32'hDEAD_BEEF);
        tick();
        setW(1'b0, 1'b0, 5'd0, 2'd0, 32'h0);
        @(negedge clk);
        chk("ld_data_hold", bus.o_load_data, 32'hDEAD_BEEF);
        tick();

        // Load with no data: timeout pulse in the 9th stall cycle, then write 0.
        setW(1'b1, 1'b1, 5'd9, 2'd2, 32'h0);
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (bus.o_stall) stalls++;
            if (bus.o_ld_timeout) begin
                seen = 1'b1;
                chk("to_stall_count", 32'(stalls), 32'(TO + 1));
                chk("to_stall_at_pulse", 32'(bus.o_stall), 32'd1);
            end
            tick();
        end
        chk("to_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("to_commit_we",    32'(bus.o_rf_we), 32'd1);
        chk("to_commit_rd",    32'(bus.o_rf_rd), 32'd9);
        chk("to_commit_wdata", bus.o_rf_wdata, 32'd0);
        chk("to_commit_stall", 32'(bus.o_stall), 32'd0);
        chk("to_pulse_once",   32'(bus.o_ld_timeout), 32'd0);
        tick();

        // Debug request starved by pipeline writes: forced grant on 5th cycle.
        setW(1'b1, 1'b1, 5'd5, 2'd3, 32'h55);
        setDbg(1'b1, 5'd3, 32'hA5);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 4) begin
                chk($sformatf("dbg_wait_ack_c%0d", c),   32'(bus.o_dbg_wr_ack), 32'd0);
                chk($sformatf("dbg_wait_rd_c%0d", c),    32'(bus.o_rf_rd), 32'd5);
                chk($sformatf("dbg_wait_stall_c%0d", c), 32'(bus.o_stall), 32'd0);
            end else begin
                chk("dbg_force_ack",   32'(bus.o_dbg_wr_ack), 32'd1);
                chk("dbg_force_stall", 32'(bus.o_stall), 32'd1);
                chk("dbg_force_we",    32'(bus.o_rf_we), 32'd1);
                chk("dbg_force_rd",    32'(bus.o_rf_rd), 32'd3);
                chk("dbg_force_wdata", bus.o_rf_wdata, 32'hA5);
            end
            tick();
        end
        setDbg(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("dbg_after_rd",  32'(bus.o_rf_rd), 32'd5);
        chk("dbg_after_ack", 32'(bus.o_dbg_wr_ack), 32'd0);
        tick();

        // Load to x0: stalls until data, commit writes nothing.
        setW(1'b1, 1'b1, 5'd0, 2'd2, 32'h0);
        @(negedge clk);
        chk("ldx0_stall0", 32'(bus.o_stall), 32'd1);
        tick();
        bus.i_dmem_rvalid = 1'b1;
        bus.i_dmem_rdata  = 32'h77;
        @(negedge clk);
        chk("ldx0_stall1", 32'(bus.o_stall), 32'd1);
        tick();
        bus.i_dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("ldx0_commit_stall", 32'(bus.o_stall), 32'd0);
        chk("ldx0_commit_we",    32'(bus.o_rf_we), 32'd0);
        chk("ldx0_ldata",        bus.o_load_data, 32'h77);
        tick();

        // Reset in the middle of LD_WAIT; a later rvalid must be ignored.
        setW(1'b1, 1'b1, 5'd12, 2'd2, 32'h0);
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        chk("midrst_stall", 32'(bus.o_stall), 32'd0);
        chk("midrst_we",    32'(bus.o_rf_we), 32'd0);
        chk("midrst_ldata", bus.o_load_data, 32'd0);
        setW(1'b0, 1'b0, 5'd0, 2'd0, 32'h0);
        tick();
        rstn = 1'b1;
        bus.i_dmem_rvalid = 1'b1;
        bus.i_dmem_rdata  = 32'hBAD0;
        @(negedge clk);
        chk("postrst_stall", 32'(bus.o_stall), 32'd0);
        chk("postrst_we",    32'(bus.o_rf_we), 32'd0);
        tick();
        bus.i_dmem_rvalid = 1'b0;
        @(negedge clk);
        chk("postrst_no_commit", 32'(bus.o_rf_we), 32'd0);
        chk("postrst_ldata",     bus.o_load_data, 32'd0);
        tick();

        // Random traffic against the reference model.
        mWait = 0; mCommit = 0; mAge = 0; mDbgWait = 0; mBuf = '0;
        for (int n = 0; n < 3000; n++) begin
            setW($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom);
            bus.i_dmem_rvalid = ($urandom_range(0, 5) == 0);
            bus.i_dmem_rdata  = $urandom;
            if (!bus.i_dbg_wr_req && $urandom_range(0, 4) == 0)
                setDbg(1'b1, 5'($urandom_range(0, 7)), $urandom);
            @(negedge clk);

            isLd   = bus.i_wb_valid && (bus.i_wb_resultsrc == 2'd2);
            eStall = 0; eWe = 0; eAck = 0; eTo = 0;
            eSrc   = bus.i_wb_resultsrc;
            eRd    = bus.i_wb_rd;
            eWd    = bus.i_dp_resultW;
            nBuf   = mBuf;
            if (mCommit) begin
                eSrc    = 2'd2;
                eWe     = bus.i_wb_regwrite && (bus.i_wb_rd != 5'd0);
                eWd     = mBuf;
                mCommit = 0;
            end else if (mWait) begin
                eStall = 1;
                eSrc   = 2'd2;
                if (bus.i_dmem_rvalid) begin
                    nBuf = bus.i_dmem_rdata; mWait = 0; mCommit = 1;
                end else if (mAge == TO - 1) begin
                    eTo = 1; nBuf = '0; mWait = 0; mCommit = 1;
                end else begin
                    mAge++;
                end
            end else if (isLd) begin
                eStall = 1;
                if (bus.i_dmem_rvalid) begin
                    nBuf = bus.i_dmem_rdata; mCommit = 1;
                end else begin
                    mWait = 1; mAge = 0;
                end
            end else begin
                pipeWr = bus.i_wb_valid && bus.i_wb_regwrite && (bus.i_wb_rd != 5'd0);
                forceG = bus.i_dbg_wr_req && (mDbgWait == DMW);
                grantM = bus.i_dbg_wr_req && (!pipeWr || forceG);
                if (grantM) begin
                    eAck   = 1;
                    eWe    = (bus.i_dbg_rd != 5'd0);
                    eRd    = bus.i_dbg_rd;
                    eWd    = bus.i_dbg_wdata;
                    eStall = forceG;
                end else begin
                    eWe = pipeWr;
                end
            end

            chk("rnd_stall", 32'(bus.o_stall), 32'(eStall));
            chk("rnd_we",    32'(bus.o_rf_we), 32'(eWe));
            chk("rnd_ack",   32'(bus.o_dbg_wr_ack), 32'(eAck));
            chk("rnd_to",    32'(bus.o_ld_timeout), 32'(eTo));
            chk("rnd_src",   32'(bus.o_resultsrc), 32'(eSrc));
            chk("rnd_ldata", bus.o_load_data, mBuf);
            if (eWe) begin
                chk("rnd_rd",    32'(bus.o_rf_rd), 32'(eRd));
                chk("rnd_wdata", bus.o_rf_wdata, eWd);
            end

            mBuf = nBuf;
            if (eAck) mDbgWait = 0;
            else if (bus.i_dbg_wr_req && mDbgWait < DMW) mDbgWait++;
            gotAck = bus.o_dbg_wr_ack;
            tick();
            if (gotAck) setDbg(1'b0, 5'd0, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
